// File: rtl/control_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Hardwired Moore sequencer for the single-bus datapath.
//               Fetch T0-T2, opcode-dependent execute T3-T7, HALT.
// Revision    : 1.0 - initial release
// ============================================================================
module control_unit #(
    parameter int INCPC_OP = 14,
    parameter int OPW      = 5
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        con_ff,
    output logic [31:0] enable,
    output logic [31:0] busSelect,
    output logic [4:0]  Control_Signals,
    output logic        MD_Read,
    output logic        ReadRAM,
    output logic        WriteRAM,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        run
);

    localparam int c_en_z   = 18;
    localparam int c_en_y   = 19;
    localparam int c_en_pc  = 20;
    localparam int c_en_mdr = 21;
    localparam int c_en_out = 22;
    localparam int c_en_con = 23;
    localparam int c_en_ir  = 24;
    localparam int c_en_mar = 25;
    localparam int c_en_hi  = 26;
    localparam int c_en_lo  = 27;

    localparam int c_bs_hi  = 16;
    localparam int c_bs_lo  = 17;
    localparam int c_bs_zh  = 18;
    localparam int c_bs_zl  = 19;
    localparam int c_bs_pc  = 20;
    localparam int c_bs_mdr = 21;
    localparam int c_bs_in  = 22;
    localparam int c_bs_c   = 23;

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    state_t           r_state;
    logic [OPW-1:0]   w_op;
    logic             w_unused_ir;
    logic             w_rtype, w_imm, w_ldi, w_ld, w_st, w_muldiv, w_negnot;
    logic             w_br, w_jr, w_in, w_out, w_mfhi, w_mflo, w_halt, w_skip;
    logic [2:0]       w_last;
    logic [4:0]       w_alu;

    assign w_op        = ir[31 -: OPW];
    assign w_unused_ir = ^ir[31-OPW:0];

    always_comb begin
        w_rtype  = (w_op >= OPW'(3))  && (w_op <= OPW'(11));
        w_imm    = (w_op >= OPW'(12)) && (w_op <= OPW'(14));
        w_ld     = (w_op == OPW'(0));
        w_ldi    = (w_op == OPW'(1));
        w_st     = (w_op == OPW'(2));
        w_muldiv = (w_op == OPW'(15)) || (w_op == OPW'(16));
        w_negnot = (w_op == OPW'(17)) || (w_op == OPW'(18));
        w_br     = (w_op == OPW'(19));
        w_jr     = (w_op == OPW'(20));
        w_in     = (w_op == OPW'(22));
        w_out    = (w_op == OPW'(23));
        w_mfhi   = (w_op == OPW'(24));
        w_mflo   = (w_op == OPW'(25));
        w_halt   = (w_op == OPW'(27));
        w_skip   = (w_op == OPW'(21)) || (w_op == OPW'(26)) || (w_op >= OPW'(28));
    end

    // Final execute step per opcode class; the step after it returns to T0.
    always_comb begin
        w_last = 3'd3;
        if (w_rtype || w_imm || w_ldi)  w_last = 3'd5;
        else if (w_ld || w_st)          w_last = 3'd7;
        else if (w_muldiv || w_br)      w_last = 3'd6;
        else if (w_negnot)              w_last = 3'd4;
    end

    always_comb begin
        w_alu = 5'd0;
        case (w_op)
            OPW'(4):  w_alu = 5'd1;
            OPW'(5):  w_alu = 5'd2;
            OPW'(6):  w_alu = 5'd3;
            OPW'(7):  w_alu = 5'd4;
            OPW'(8):  w_alu = 5'd5;
            OPW'(9):  w_alu = 5'd6;
            OPW'(10): w_alu = 5'd7;
            OPW'(11): w_alu = 5'd8;
            OPW'(13): w_alu = 5'd2;
            OPW'(14): w_alu = 5'd3;
            OPW'(15): w_alu = 5'd9;
            OPW'(16): w_alu = 5'd10;
            OPW'(17): w_alu = 5'd11;
            OPW'(18): w_alu = 5'd12;
            default:  w_alu = 5'd0;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= S_RESET;
        end else begin
            case (r_state)
                S_RESET: r_state <= S_T0;
                S_T0:    r_state <= S_T1;
                S_T1:    r_state <= S_T2;
                S_T2:    r_state <= w_halt ? S_HALT : (w_skip ? S_T0 : S_T3);
                S_T3:    r_state <= (w_last == 3'd3) ? S_T0 : S_T4;
                S_T4:    r_state <= (w_last == 3'd4) ? S_T0 : S_T5;
                S_T5:    r_state <= (w_last == 3'd5) ? S_T0 : S_T6;
                S_T6:    r_state <= (w_last == 3'd6) ? S_T0 : S_T7;
                S_T7:    r_state <= S_T0;
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_RESET;
            endcase
        end
    end

    always_comb begin
        enable          = '0;
        busSelect       = '0;
        Control_Signals = '0;
        MD_Read         = 1'b0;
        ReadRAM         = 1'b0;
        WriteRAM        = 1'b0;
        Gra             = 1'b0;
        Grb             = 1'b0;
        Grc             = 1'b0;
        Rin             = 1'b0;
        Rout            = 1'b0;
        BAout           = 1'b0;
        run             = (r_state != S_RESET) && (r_state != S_HALT);
        case (r_state)
            S_T0: begin
                busSelect[c_bs_pc] = 1'b1;
                enable[c_en_mar]   = 1'b1;
                enable[c_en_z]     = 1'b1;
                Control_Signals    = 5'(INCPC_OP);
            end
            S_T1: begin
                busSelect[c_bs_zl] = 1'b1;
                enable[c_en_pc]    = 1'b1;
                enable[c_en_mdr]   = 1'b1;
                MD_Read            = 1'b1;
                ReadRAM            = 1'b1;
            end
            S_T2: begin
                busSelect[c_bs_mdr] = 1'b1;
                enable[c_en_ir]     = 1'b1;
            end
            S_T3: begin
                if (w_rtype || w_imm) begin
                    Grb = 1'b1; Rout = 1'b1; enable[c_en_y] = 1'b1;
                end else if (w_ld || w_ldi || w_st) begin
                    Grb = 1'b1; BAout = 1'b1; enable[c_en_y] = 1'b1;
                end else if (w_muldiv) begin
                    Gra = 1'b1; Rout = 1'b1; enable[c_en_y] = 1'b1;
                end else if (w_negnot) begin
                    Grb = 1'b1; Rout = 1'b1; enable[c_en_z] = 1'b1;
                    Control_Signals = w_alu;
                end else if (w_br) begin
                    Gra = 1'b1; Rout = 1'b1; enable[c_en_con] = 1'b1;
                end else if (w_jr) begin
                    Gra = 1'b1; Rout = 1'b1; enable[c_en_pc] = 1'b1;
                end else if (w_in) begin
                    busSelect[c_bs_in] = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (w_out) begin
                    Gra = 1'b1; Rout = 1'b1; enable[c_en_out] = 1'b1;
                end else if (w_mfhi) begin
                    busSelect[c_bs_hi] = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (w_mflo) begin
                    busSelect[c_bs_lo] = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end
            end
            S_T4: begin
                if (w_rtype) begin
                    Grc = 1'b1; Rout = 1'b1; enable[c_en_z] = 1'b1;
                    Control_Signals = w_alu;
                end else if (w_imm || w_ld || w_ldi || w_st) begin
                    busSelect[c_bs_c] = 1'b1; enable[c_en_z] = 1'b1;
                    Control_Signals = w_alu;
                end else if (w_muldiv) begin
                    Grb = 1'b1; Rout = 1'b1; enable[c_en_z] = 1'b1;
                    Control_Signals = w_alu;
                end else if (w_negnot) begin
                    busSelect[c_bs_zl] = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (w_br) begin
                    busSelect[c_bs_pc] = 1'b1; enable[c_en_y] = 1'b1;
                end
            end
            S_T5: begin
                if (w_rtype || w_imm || w_ldi) begin
                    busSelect[c_bs_zl] = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (w_ld || w_st) begin
                    busSelect[c_bs_zl] = 1'b1; enable[c_en_mar] = 1'b1;
                end else if (w_muldiv) begin
                    busSelect[c_bs_zl] = 1'b1; enable[c_en_lo] = 1'b1;
                end else if (w_br) begin
                    busSelect[c_bs_c] = 1'b1; enable[c_en_z] = 1'b1;
                end
            end
            S_T6: begin
                if (w_ld) begin
                    MD_Read = 1'b1; ReadRAM = 1'b1; enable[c_en_mdr] = 1'b1;
                end else if (w_st) begin
                    Gra = 1'b1; Rout = 1'b1; enable[c_en_mdr] = 1'b1;
                end else if (w_muldiv) begin
                    busSelect[c_bs_zh] = 1'b1; enable[c_en_hi] = 1'b1;
                end else if (w_br && con_ff) begin
                    busSelect[c_bs_zl] = 1'b1; enable[c_en_pc] = 1'b1;
                end
            end
            S_T7: begin
                if (w_ld) begin
                    busSelect[c_bs_mdr] = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (w_st) begin
                    WriteRAM = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/control_unit.md
Name: control_unit

Overview:
- Hardwired Moore control sequencer for the single-bus datapath (the `datapath` module).
- Drives the datapath's `enable` and `busSelect` strobe vectors, the ALU opcode, register-select/RAM controls and `MD_Read`.
- Runs a 3-step fetch (T0–T2) and an opcode-dependent execute (T3–T7), then returns to T0.
- Replaces hand-sequenced testbench stimulus.

Parameters:
- INCPC_OP, 14, ALU code for PC+1 on `Control_Signals`.
- OPW, 5, opcode width taken from `ir[31:27]`.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous active-low reset.
- ir  in  32  instruction register contents; opcode = `ir[31:27]`.
- con_ff  in  1  branch condition flag from CON FF.
- enable  out  32  register load strobes.
- busSelect  out  32  bus driver selects; bits 15:0 are always 0 (GPRs are driven via `Gra`/`Grb`/`Grc` + `Rout`).
- Control_Signals  out  5  ALU op.
- MD_Read  out  1  MDR mux selects memory.
- ReadRAM, WriteRAM  out  1 each  RAM strobes.
- Gra, Grb, Grc  out  1 each  register field selects.
- Rin, Rout, BAout  out  1 each  GPR in/out and base-address out.
- run  out  1  high while executing; low in HALT.

Behaviour:
- enable bit map:
  - 18 Zin, 19 Yin, 20 PCin, 21 MDRin, 22 OutPortIn, 23 CONin, 24 IRin, 25 MARin, 26 HIin, 27 LOin.
  - All other bits are 0.
- busSelect bit map:
  - 16 HIout, 17 LOout, 18 ZHighOut, 19 ZLowOut, 20 PCout, 21 MDRout, 22 InPortOut, 23 Cout.
- ALU codes:
  - ADD0, SUB1, AND2, OR3, SHR4, SHRA5, SHL6, ROR7, ROL8, MUL9, DIV10, NEG11, NOT12, INCPC=INCPC_OP.
  - Immediate forms reuse ADD/AND/OR.
- State register holds {RESET, T0–T7, HALT}.
- Outputs are decoded combinationally from state and opcode only. Each asserted signal is valid for exactly one full clock; unlisted outputs are 0.
- `clr`=0 at any time, including mid-instruction:
  - state = RESET, all outputs 0, `run` = 0.
  - First posedge after release moves to T0 with `run` = 1.
- Fetch (all opcodes):
  - T0: PCout, MARin, Control_Signals=INCPC_OP, Zin.
  - T1: ZLowOut, PCin, MDRin, MD_Read, ReadRAM.
  - T2: MDRout, IRin.
  - T3 decodes the opcode from the updated `ir`.
- Execute; after the last listed step → T0:
  - R-type (add 3, sub 4, and 5, or 6, shr 7, shra 8, shl 9, ror 10, rol 11):
    - T3 Grb Rout Yin.
    - T4 Grc Rout op Zin.
    - T5 ZLowOut Gra Rin.
  - Immediate (addi 12, andi 13, ori 14):
    - T3 Grb Rout Yin.
    - T4 Cout op Zin.
    - T5 ZLowOut Gra Rin.
  - ldi 1:
    - T3 Grb BAout Yin.
    - T4 Cout ADD Zin.
    - T5 ZLowOut Gra Rin.
  - ld 0:
    - T3 and T4 as ldi.
    - T5 ZLowOut MARin.
    - T6 MD_Read ReadRAM MDRin.
    - T7 MDRout Gra Rin.
  - st 2:
    - T3 and T4 as ldi.
    - T5 ZLowOut MARin.
    - T6 Gra Rout MDRin (MD_Read=0).
    - T7 WriteRAM.
  - mul 15 / div 16:
    - T3 Gra Rout Yin.
    - T4 Grb Rout op Zin.
    - T5 ZLowOut LOin.
    - T6 ZHighOut HIin.
  - neg 17 / not 18:
    - T3 Grb Rout op Zin.
    - T4 ZLowOut Gra Rin.
  - br 19:
    - T3 Gra Rout CONin.
    - T4 PCout Yin.
    - T5 Cout ADD Zin.
    - T6 ZLowOut plus PCin, asserted only if `con_ff`=1 sampled in T6; otherwise T6 drives nothing.
  - jr 20: T3 Gra Rout PCin.
  - in 22: T3 InPortOut Gra Rin.
  - out 23: T3 Gra Rout OutPortIn.
  - mfhi 24: T3 HIout Gra Rin.
  - mflo 25: T3 LOout Gra Rin.
  - nop 26, jal 21 and opcodes 28–31: T2 → T0 directly (no execute steps).
  - halt 27: T2 → HALT. All outputs 0 and `run` = 0 until `clr` asserts.
- Opcode changes while in T3–T7 are not expected. The controller decodes `ir` every step, and the bench holds `ir` stable.

Test Plan:
- Reset: drive `clr`=0 for 2 cycles, then release → `enable`=0, `busSelect`=0, `run`=0 during reset. T0 on the next cycle shows `enable[25]`, `enable[18]`, `busSelect[20]`, `Control_Signals`=14.
- add: `ir`=0x18918000 (add r1,r2,r3) → 6 cycles. T4 shows `Control_Signals`=0, `Grc`, `Rout`, `enable[18]`. T5 shows `busSelect[19]`, `Gra`, `Rin`. Next cycle is T0.
- ld: `ir`=0x00800055 → 8 cycles. T6 shows `MD_Read`, `ReadRAM`, `enable[21]`. T7 shows `busSelect[21]`, `Gra`, `Rin`.
- st: `ir`=0x10800055 → T7 `WriteRAM`=1 and `MD_Read`=0. `WriteRAM` is never asserted in any other step.
- Branch: `ir`=0x98880010 with `con_ff`=1 → T6 `busSelect[19]` and `enable[20]` both high. Repeat with `con_ff`=0 → T6 all outputs 0.
- Halt and reset mid-instruction:
  - `ir`=0xD8000000 → HALT after T2; `run`=0 held for 10 cycles.
  - Separately, assert `clr`=0 during T4 of a mul → outputs go to 0 asynchronously, and execution restarts at T0.
